// File: rtl/stack_issue.sv
// Dual-slot push/pop issue stage for an external stack block.
// Tracks shadow occupancy, flags overflow/underflow and returns pop data.
module stack_issue #(
  parameter int DW          = 32,
  parameter int DEPTH       = 1024,
  parameter int RD_LAT      = 2,
  parameter int HALT_ON_ERR = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld0,
  input  logic          vld1,
  input  logic [1:0]    op0,
  input  logic [1:0]    op1,
  input  logic [DW-1:0] src0,
  input  logic [DW-1:0] src1,
  input  logic [4:0]    dst0,
  input  logic [4:0]    dst1,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          err_clr,
  input  logic [DW-1:0] stack_rdata0,
  input  logic [DW-1:0] stack_rdata1,
  output logic          push0,
  output logic          push1,
  output logic          pop0,
  output logic          pop1,
  output logic [DW-1:0] wdata0,
  output logic [DW-1:0] wdata1,
  output logic          accept,
  output logic          wb_en0,
  output logic          wb_en1,
  output logic [4:0]    wb_dst0,
  output logic [4:0]    wb_dst1,
  output logic [DW-1:0] wb_data0,
  output logic [DW-1:0] wb_data1,
  output logic [10:0]   depth,
  output logic          ovf_err,
  output logic          unf_err,
  output logic          halted
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [10:0] FULL = 11'(DEPTH);

  state_t state;

  logic        is_push0, is_pop0;
  logic        is_push1, is_pop1;
  logic        ok_push0, ok_pop0;
  logic        ok_push1, ok_pop1;
  logic        new_ovf, new_unf;
  logic [10:0] d1, d2;
  logic [4:0]  pdst0, pdst1;

  logic [RD_LAT-1:0] pen0, pen1;
  logic [4:0]        pd0 [RD_LAT];
  logic [4:0]        pd1 [RD_LAT];

  assign accept = (state == RUN) & ~stall_in & ~flush;

  assign is_push0 = vld0 & (op0 == 2'b01);
  assign is_pop0  = vld0 & (op0 == 2'b10);
  assign is_push1 = vld1 & (op1 == 2'b01);
  assign is_pop1  = vld1 & (op1 == 2'b10);

  // slot 1 sees the occupancy left behind by slot 0
  assign ok_push0 = is_push0 & (depth != FULL);
  assign ok_pop0  = is_pop0 & (depth != 11'd0);
  assign d1 = depth + {10'd0, ok_push0}
                    - {10'd0, ok_pop0};
  assign ok_push1 = is_push1 & (d1 != FULL);
  assign ok_pop1  = is_pop1 & (d1 != 11'd0);
  assign d2 = d1 + {10'd0, ok_push1}
                 - {10'd0, ok_pop1};

  assign new_ovf = accept &
    ((is_push0 & ~ok_push0) | (is_push1 & ~ok_push1));
  assign new_unf = accept &
    ((is_pop0 & ~ok_pop0) | (is_pop1 & ~ok_pop1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push0  <= 1'b0;
      push1  <= 1'b0;
      pop0   <= 1'b0;
      pop1   <= 1'b0;
      wdata0 <= '0;
      wdata1 <= '0;
      pdst0  <= '0;
      pdst1  <= '0;
      depth  <= '0;
    end else begin
      push0  <= accept & ok_push0;
      push1  <= accept & ok_push1;
      pop0   <= accept & ok_pop0;
      pop1   <= accept & ok_pop1;
      wdata0 <= (accept & ok_push0) ? src0 : '0;
      wdata1 <= (accept & ok_push1) ? src1 : '0;
      pdst0  <= (accept & ok_pop0) ? dst0 : '0;
      pdst1  <= (accept & ok_pop1) ? dst1 : '0;
      if (accept) depth <= d2;
    end
  end

  // free-running: in-flight pops drain even while stalled or halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen0 <= '0;
      pen1 <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd0[i] <= '0;
        pd1[i] <= '0;
      end
    end else begin
      pen0[0] <= pop0;
      pen1[0] <= pop1;
      pd0[0]  <= pdst0;
      pd1[0]  <= pdst1;
      for (int i = 1; i < RD_LAT; i++) begin
        pen0[i] <= pen0[i-1];
        pen1[i] <= pen1[i-1];
        pd0[i]  <= pd0[i-1];
        pd1[i]  <= pd1[i-1];
      end
    end
  end

  assign wb_en0   = pen0[RD_LAT-1];
  assign wb_en1   = pen1[RD_LAT-1];
  assign wb_dst0  = pd0[RD_LAT-1];
  assign wb_dst1  = pd1[RD_LAT-1];
  assign wb_data0 = wb_en0 ? stack_rdata0 : '0;
  assign wb_data1 = wb_en1 ? stack_rdata1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      halted  <= 1'b0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      ovf_err <= new_ovf | (ovf_err & ~err_clr);
      unf_err <= new_unf | (unf_err & ~err_clr);
      unique case (state)
        RUN: begin
          if ((HALT_ON_ERR != 0) && (new_ovf | new_unf)) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (err_clr) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_issue.sv
// Randomized bench for stack_issue with an occupancy-counting reference model.
// Directed scenarios pin the model with literal expectations.
module tb_stack_issue;

  localparam int DW     = 32;
  localparam int DEPTH  = 6;
  localparam int RD_LAT = 2;
  localparam int HOE    = 1;

  logic          clk = 0;
  logic          rst_n = 1;
  logic          vld0 = 0, vld1 = 0;
  logic [1:0]    op0 = 0, op1 = 0;
  logic [DW-1:0] src0 = 0, src1 = 0;
  logic [4:0]    dst0 = 0, dst1 = 0;
  logic          stall_in = 0, flush = 0, err_clr = 0;
  logic [DW-1:0] stack_rdata0 = 0, stack_rdata1 = 0;
  logic          push0, push1, pop0, pop1;
  logic [DW-1:0] wdata0, wdata1;
  logic          accept;
  logic          wb_en0, wb_en1;
  logic [4:0]    wb_dst0, wb_dst1;
  logic [DW-1:0] wb_data0, wb_data1;
  logic [10:0]   depth;
  logic          ovf_err, unf_err, halted;

  int checks = 0;
  int failures = 0;

  stack_issue #(
    .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .HALT_ON_ERR(HOE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vld0(vld0), .vld1(vld1), .op0(op0), .op1(op1),
    .src0(src0), .src1(src1), .dst0(dst0), .dst1(dst1),
    .stall_in(stall_in), .flush(flush), .err_clr(err_clr),
    .stack_rdata0(stack_rdata0), .stack_rdata1(stack_rdata1),
    .push0(push0), .push1(push1), .pop0(pop0), .pop1(pop1),
    .wdata0(wdata0), .wdata1(wdata1), .accept(accept),
    .wb_en0(wb_en0), .wb_en1(wb_en1),
    .wb_dst0(wb_dst0), .wb_dst1(wb_dst1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  // reference model: occupancy counter plus per-cycle pop history
  int          m_depth = 0;
  bit          m_ovf = 0, m_unf = 0, m_halt = 0;
  bit          e_push[2], e_pop[2];
  logic [DW-1:0] e_wd[2];
  bit          e_wb_en[2];
  logic [4:0]  e_wb_dst[2];
  bit          r_en[2][8];
  logic [4:0]  r_dst[2][8];
  int          k = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_depth = 0; m_ovf = 0; m_unf = 0; m_halt = 0; k = 0;
      for (int s = 0; s < 2; s++) begin
        e_push[s] = 0; e_pop[s] = 0; e_wd[s] = 0;
        e_wb_en[s] = 0; e_wb_dst[s] = 0;
        for (int j = 0; j < 8; j++) begin
          r_en[s][j] = 0; r_dst[s][j] = 0;
        end
      end
    end else begin
      bit acc, no, nu;
      int d;
      bit v;
      logic [1:0] o;
      acc = !m_halt && !stall_in && !flush;
      no = 0; nu = 0; d = m_depth;
      for (int s = 0; s < 2; s++) begin
        e_push[s] = 0; e_pop[s] = 0; e_wd[s] = 0;
        v = s ? vld1 : vld0;
        o = s ? op1 : op0;
        if (acc && v && o == 2'b01) begin
          if (d == DEPTH) no = 1;
          else begin
            d++; e_push[s] = 1; e_wd[s] = s ? src1 : src0;
          end
        end
        if (acc && v && o == 2'b10) begin
          if (d == 0) nu = 1;
          else begin d--; e_pop[s] = 1; end
        end
      end
      m_depth = d;
      m_ovf = no | (m_ovf & !err_clr);
      m_unf = nu | (m_unf & !err_clr);
      if (!m_halt) begin
        if (HOE != 0 && (no || nu)) m_halt = 1;
      end else if (err_clr) m_halt = 0;
      k++;
      for (int s = 0; s < 2; s++) begin
        r_en[s][k%8]  = e_pop[s];
        r_dst[s][k%8] = s ? dst1 : dst0;
        e_wb_en[s]  = r_en[s][(k+8-RD_LAT)%8];
        e_wb_dst[s] = r_dst[s][(k+8-RD_LAT)%8];
      end
    end
  end

  // compare process: one time unit before each active edge
  initial forever begin
    @(posedge clk);
    #9;
    cmp("accept", accept, !m_halt && !stall_in && !flush);
    cmp("push0", push0, e_push[0]);
    cmp("push1", push1, e_push[1]);
    cmp("pop0", pop0, e_pop[0]);
    cmp("pop1", pop1, e_pop[1]);
    if (e_push[0]) cmp("wdata0", wdata0, e_wd[0]);
    if (e_push[1]) cmp("wdata1", wdata1, e_wd[1]);
    cmp("depth", depth, m_depth);
    cmp("ovf_err", ovf_err, m_ovf);
    cmp("unf_err", unf_err, m_unf);
    cmp("halted", halted, m_halt);
    cmp("wb_en0", wb_en0, e_wb_en[0]);
    cmp("wb_en1", wb_en1, e_wb_en[1]);
    if (e_wb_en[0]) cmp("wb_dst0", wb_dst0, e_wb_dst[0]);
    if (e_wb_en[1]) cmp("wb_dst1", wb_dst1, e_wb_dst[1]);
    cmp("wb_data0", wb_data0, e_wb_en[0] ? stack_rdata0 : '0);
    cmp("wb_data1", wb_data1, e_wb_en[1] ? stack_rdata1 : '0);
  end

  task automatic set_in(input logic v0, input logic [1:0] o0,
                        input logic [DW-1:0] s0, input logic [4:0] d0,
                        input logic v1, input logic [1:0] o1,
                        input logic [DW-1:0] s1, input logic [4:0] d1,
                        input logic st, input logic fl,
                        input logic cl);
    @(negedge clk);
    vld0 = v0; op0 = o0; src0 = s0; dst0 = d0;
    vld1 = v1; op1 = o1; src1 = s1; dst1 = d1;
    stall_in = st; flush = fl; err_clr = cl;
    stack_rdata0 = $urandom; stack_rdata1 = $urandom;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 0;
    idle(); idle();
    #1;
    cmp("rst_depth", depth, 0);
    cmp("rst_halted", halted, 0);
    cmp("rst_push0", push0, 0);
    cmp("rst_wb_en0", wb_en0, 0);
    @(negedge clk) rst_n = 1;

    // two pushes from empty
    set_in(1, 2'b01, 32'hA, 0, 1, 2'b01, 32'hB, 0, 0, 0, 0);
    after_edge();
    cmp("r20_push0", push0, 1);
    cmp("r20_push1", push1, 1);
    cmp("r20_wdata0", wdata0, 32'hA);
    cmp("r20_wdata1", wdata1, 32'hB);
    cmp("r20_depth", depth, 2);

    // two pops, writeback RD_LAT later
    set_in(1, 2'b10, 0, 3, 1, 2'b10, 0, 4, 0, 0, 0);
    after_edge();
    cmp("r21_pop0", pop0, 1);
    cmp("r21_pop1", pop1, 1);
    cmp("r21_depth", depth, 0);
    idle(); after_edge();
    cmp("r21_early_wb", wb_en0, 0);
    idle(); after_edge();
    cmp("r21_wb_en0", wb_en0, 1);
    cmp("r21_wb_en1", wb_en1, 1);
    cmp("r21_wb_dst0", wb_dst0, 3);
    cmp("r21_wb_dst1", wb_dst1, 4);
    cmp("r21_wb_data0", wb_data0, stack_rdata0);

    // fill to DEPTH-1 then overflow
    repeat (2) set_in(1, 2'b01, 1, 0, 1, 2'b01, 2, 0, 0, 0, 0);
    set_in(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    cmp("r22_pre_depth", depth, DEPTH-1);
    set_in(1, 2'b01, 4, 0, 1, 2'b01, 5, 0, 0, 0, 0);
    after_edge();
    cmp("r22_push0", push0, 1);
    cmp("r22_push1", push1, 0);
    cmp("r22_ovf", ovf_err, 1);
    cmp("r22_depth", depth, DEPTH);
    cmp("r22_halted", halted, 1);
    set_in(1, 2'b01, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 cmp("r22_no_accept", accept, 0);
    after_edge();
    cmp("r22_no_push", push0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    after_edge();
    cmp("r22_clr_halted", halted, 0);
    cmp("r22_clr_ovf", ovf_err, 0);

    // drain, then pop0+push1 at empty
    repeat (3) set_in(1, 2'b10, 0, 1, 1, 2'b10, 0, 2, 0, 0, 0);
    after_edge();
    cmp("r23_empty", depth, 0);
    set_in(1, 2'b10, 0, 5, 1, 2'b01, 32'h77, 0, 0, 0, 0);
    after_edge();
    cmp("r23_pop0", pop0, 0);
    cmp("r23_push1", push1, 1);
    cmp("r23_unf", unf_err, 1);
    cmp("r23_depth", depth, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    set_in(1, 2'b10, 0, 6, 0, 0, 0, 0, 0, 0, 0);
    set_in(1, 2'b01, 9, 0, 1, 2'b10, 0, 8, 0, 0, 0);
    after_edge();
    cmp("r23_mix_push0", push0, 1);
    cmp("r23_mix_pop1", pop1, 1);
    cmp("r23_mix_depth", depth, 0);
    idle(); idle(); after_edge();
    cmp("r23_wb_en1", wb_en1, 1);
    cmp("r23_wb_dst1", wb_dst1, 8);

    // stall holds a pop, flush does not kill in-flight pops
    set_in(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      set_in(1, 2'b10, 0, 9, 0, 0, 0, 0, 1, 0, 0);
      after_edge();
      cmp("r24_stall_pop", pop0, 0);
      cmp("r24_stall_depth", depth, 1);
    end
    set_in(1, 2'b10, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    cmp("r24_pop0", pop0, 1);
    cmp("r24_depth", depth, 0);
    set_in(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    after_edge();
    cmp("r24_flush_push", push0, 0);
    set_in(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    after_edge();
    cmp("r24_flush_wb", wb_en0, 1);
    cmp("r24_flush_depth", depth, 0);

    // reset right behind a pop
    set_in(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1, 2'b10, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    cmp("r25_pop0", pop0, 1);
    idle();
    rst_n = 0;
    #1;
    cmp("r25_rst_pop0", pop0, 0);
    cmp("r25_rst_depth", depth, 0);
    cmp("r25_rst_wb", wb_en0, 0);
    @(negedge clk) rst_n = 1;
    repeat (4) begin
      after_edge();
      cmp("r25_no_wb", wb_en0, 0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      vld0 = $urandom; vld1 = $urandom;
      op0 = 2'($urandom); op1 = 2'($urandom);
      src0 = $urandom; src1 = $urandom;
      dst0 = 5'($urandom); dst1 = 5'($urandom);
      stall_in = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      stack_rdata0 = $urandom; stack_rdata1 = $urandom;
    end
    @(negedge clk) rst_n = 1;
    idle(); idle();
    after_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
